vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator; successor to the fixed-mode `vga_timing`. It produces horizontal/vertical counters, sync, blanking and frame/line markers for any mode set by parameters. It also adds a pixel-enable input for clock-divided operation and start-of-frame/end-of-line pulses. It sits at the head of the video pipeline and drives `vga_if`-style signals consumed by the draw and overlay stages.

---
 rtl/vga_timing_gen.sv | 142 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Produces h/v counters plus sync, blanking, start-of-frame and end-of-line
// markers for any mode described by the porch/sync/active parameters.
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to add the 16-bit
// frame_cnt output counting completed frames.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE  = 800,
  parameter int unsigned H_FP      = 40,
  parameter int unsigned H_SYNC    = 128,
  parameter int unsigned H_BP      = 88,
  parameter int unsigned V_ACTIVE  = 600,
  parameter int unsigned V_FP      = 1,
  parameter int unsigned V_SYNC    = 4,
  parameter int unsigned V_BP      = 23,
  parameter logic        HSYNC_POL = 1'b1,
  parameter logic        VSYNC_POL = 1'b1,
  parameter int unsigned CNT_W     = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             sof,
  output logic             eol
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // Elaboration-time sanity checks on the mode parameters
  if (64'(H_TOTAL) > (64'(1) << CNT_W)) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL exceeds 2**CNT_W");
  end
  if (64'(V_TOTAL) > (64'(1) << CNT_W)) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL exceeds 2**CNT_W");
  end
  if (H_SYNC == 0) begin : g_h_sync_chk
    $error("vga_timing_gen: H_SYNC must be non-zero");
  end
  if (V_SYNC == 0) begin : g_v_sync_chk
    $error("vga_timing_gen: V_SYNC must be non-zero");
  end

  logic [CNT_W-1:0] r_hcount;
  logic [CNT_W-1:0] r_vcount;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_hblnk;
  logic             r_vblnk;
  logic             r_sof;
  logic             r_eol;

  logic [CNT_W-1:0] w_h_next;
  logic [CNT_W-1:0] w_v_next;
  logic             w_h_wrap;
  logic             w_hs_act;
  logic             w_vs_act;
  logic             w_sof_next;
  logic             w_eol_next;

  // Next counter values and their decodes; registering the decodes of the
  // next counts keeps every output aligned with the counts shown with it
  always_comb begin
    w_h_wrap   = (r_hcount == H_LAST);
    w_h_next   = w_h_wrap ? '0 : r_hcount + CNT_ONE;
    w_v_next   = r_vcount;
    if (w_h_wrap) begin
      w_v_next = (r_vcount == V_LAST) ? '0 : r_vcount + CNT_ONE;
    end
    w_hs_act   = (w_h_next >= HS_FIRST) && (w_h_next <= HS_LAST);
    w_vs_act   = (w_v_next >= VS_FIRST) && (w_v_next <= VS_LAST);
    w_sof_next = (w_h_next == '0) && (w_v_next == '0);
    w_eol_next = (w_h_next == H_LAST);
  end

  // Counters and decoded outputs advance together on enabled edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcount <= '0;
      r_vcount <= '0;
      r_hsync  <= ~HSYNC_POL;
      r_vsync  <= ~VSYNC_POL;
      r_hblnk  <= 1'b0;
      r_vblnk  <= 1'b0;
      r_sof    <= 1'b0;
      r_eol    <= 1'b0;
    end else if (en) begin
      r_hcount <= w_h_next;
      r_vcount <= w_v_next;
      r_hsync  <= w_hs_act ? HSYNC_POL : ~HSYNC_POL;
      r_vsync  <= w_vs_act ? VSYNC_POL : ~VSYNC_POL;
      r_hblnk  <= (w_h_next >= H_ACT);
      r_vblnk  <= (w_v_next >= V_ACT);
      r_sof    <= w_sof_next;
      r_eol    <= w_eol_next;
    end
  end

  assign hcount = r_hcount;
  assign vcount = r_vcount;
  assign hsync  = r_hsync;
  assign vsync  = r_vsync;
  assign hblnk  = r_hblnk;
  assign vblnk  = r_vblnk;
  assign sof    = r_sof;
  assign eol    = r_eol;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Count frames on each edge that raises sof (wraps naturally at 2^16)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (en && w_sof_next) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed self-checking bench for vga_timing_gen: default 800x600 mode,
// 640x480 negative-polarity mode, and a tiny 7x5 mode for whole frames.
module tb_vga_timing_gen;

  logic clk;
  logic rst_a, en_a, rst_b, en_b, rst_c, en_c;

  logic [10:0] hc_a, vc_a, hc_b, vc_b;
  logic [3:0]  hc_c, vc_c;
  logic hs_a, vs_a, hb_a, vb_a, sof_a, eol_a;
  logic hs_b, vs_b, hb_b, vb_b, sof_b, eol_b;
  logic hs_c, vs_c, hb_c, vb_c, sof_c, eol_c;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fc_a, fc_b, fc_c;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen u_dut_a (
    .clk(clk), .rst(rst_a), .en(en_a),
    .hcount(hc_a), .vcount(vc_a), .hsync(hs_a), .vsync(vs_a),
    .hblnk(hb_a), .vblnk(vb_a), .sof(sof_a), .eol(eol_a)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc_a)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .en(en_b),
    .hcount(hc_b), .vcount(vc_b), .hsync(hs_b), .vsync(vs_b),
    .hblnk(hb_b), .vblnk(vb_b), .sof(sof_b), .eol(eol_b)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc_b)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CNT_W(4)
  ) u_dut_c (
    .clk(clk), .rst(rst_c), .en(en_c),
    .hcount(hc_c), .vcount(vc_c), .hsync(hs_c), .vsync(vs_c),
    .hblnk(hb_c), .vblnk(vb_c), .sof(sof_c), .eol(eol_c)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc_c)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned freeze_err;
    int unsigned eol_n;
    logic [10:0] prev_h;
    int h, v;

    rst_a = 1'b1; en_a = 1'b1;
    rst_b = 1'b1; en_b = 1'b1;
    rst_c = 1'b1; en_c = 1'b1;
    repeat (10) tick();

    // Reset state
    check_val("a_rst_hc",   32'(hc_a), 0);
    check_val("a_rst_vc",   32'(vc_a), 0);
    check_val("a_rst_hs",   32'(hs_a), 0);
    check_val("a_rst_vs",   32'(vs_a), 0);
    check_val("a_rst_hb",   32'(hb_a), 0);
    check_val("a_rst_vb",   32'(vb_a), 0);
    check_val("a_rst_sof",  32'(sof_a), 0);
    check_val("a_rst_eol",  32'(eol_a), 0);
    check_val("b_rst_hs",   32'(hs_b), 1);
    check_val("b_rst_vs",   32'(vs_b), 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check_val("a_rst_fc",   32'(fc_a), 0);
`endif

    // Default mode: first line
    rst_a = 1'b0;
    check_val("a_rel_hc0", 32'(hc_a), 0);
    tick();
    check_val("a_hc1", 32'(hc_a), 1);
    tick();
    check_val("a_hc2", 32'(hc_a), 2);
    repeat (797) tick();
    check_val("a_hb_799", 32'(hb_a), 0);
    tick();
    check_val("a_hb_800", 32'(hb_a), 1);
    repeat (39) tick();
    check_val("a_hc_839", 32'(hc_a), 839);
    check_val("a_hs_839", 32'(hs_a), 0);
    tick();
    check_val("a_hs_840", 32'(hs_a), 1);
    repeat (127) tick();
    check_val("a_hs_967", 32'(hs_a), 1);
    tick();
    check_val("a_hs_968", 32'(hs_a), 0);
    repeat (86) tick();
    check_val("a_eol_1054", 32'(eol_a), 0);
    tick();
    check_val("a_hc_1055", 32'(hc_a), 1055);
    check_val("a_eol_1055", 32'(eol_a), 1);
    check_val("a_vc_line0", 32'(vc_a), 0);
    tick();
    check_val("a_wrap_hc", 32'(hc_a), 0);
    check_val("a_wrap_vc", 32'(vc_a), 1);
    check_val("a_wrap_eol", 32'(eol_a), 0);
    check_val("a_wrap_sof", 32'(sof_a), 0);

    // en toggling: one line takes 2112 clocks, outputs frozen when en=0
    freeze_err = 0;
    eol_n = 0;
    for (int k = 0; k < 2112; k++) begin
      prev_h = hc_a;
      en_a = (k % 2 == 0);
      tick();
      if (!en_a && (hc_a != prev_h)) freeze_err++;
      if (eol_a) eol_n++;
    end
    en_a = 1'b1;
    check_val("a_tog_freeze", freeze_err, 0);
    check_val("a_tog_hc", 32'(hc_a), 0);
    check_val("a_tog_vc", 32'(vc_a), 2);
    check_val("a_tog_eol_len", eol_n, 2);

    // Asynchronous reset mid-line, inside hsync
    repeat (900) tick();
    check_val("a_mid_hc", 32'(hc_a), 900);
    check_val("a_mid_hs", 32'(hs_a), 1);
    check_val("a_mid_hb", 32'(hb_a), 1);
    rst_a = 1'b1;
    #1;
    check_val("a_arst_hc", 32'(hc_a), 0);
    check_val("a_arst_vc", 32'(vc_a), 0);
    check_val("a_arst_hs", 32'(hs_a), 0);
    check_val("a_arst_hb", 32'(hb_a), 0);
    repeat (3) tick();
    rst_a = 1'b0;
    check_val("a_rerel_sof", 32'(sof_a), 0);
    tick();
    check_val("a_rerel_hc", 32'(hc_a), 1);
    check_val("a_rerel_vc", 32'(vc_a), 0);
    check_val("a_rerel_sof1", 32'(sof_a), 0);
    rst_a = 1'b1;

    // 640x480, active-low syncs
    rst_b = 1'b0;
    repeat (655) tick();
    check_val("b_hs_655", 32'(hs_b), 1);
    tick();
    check_val("b_hs_656", 32'(hs_b), 0);
    repeat (95) tick();
    check_val("b_hs_751", 32'(hs_b), 0);
    tick();
    check_val("b_hs_752", 32'(hs_b), 1);
    repeat (47) tick();
    check_val("b_hc_799", 32'(hc_b), 799);
    check_val("b_eol_799", 32'(eol_b), 1);
    check_val("b_vs_idle", 32'(vs_b), 1);
    tick();
    check_val("b_wrap_hc", 32'(hc_b), 0);
    check_val("b_wrap_vc", 32'(vc_b), 1);
    rst_b = 1'b1;

    // Tiny mode: whole first frame, then frame wraps
    rst_c = 1'b0;
    for (int i = 0; i < 35; i++) begin
      h = i % 7;
      v = i / 7;
      check_val("c_hc",  32'(hc_c), h);
      check_val("c_vc",  32'(vc_c), v);
      check_val("c_hs",  32'(hs_c), 32'(h == 5));
      check_val("c_hb",  32'(hb_c), 32'(h >= 4));
      check_val("c_vs",  32'(vs_c), 32'(v == 3));
      check_val("c_vb",  32'(vb_c), 32'(v >= 2));
      check_val("c_eol", 32'(eol_c), 32'(h == 6));
      check_val("c_sof_first", 32'(sof_c), 0);
      tick();
    end
    check_val("c_wrap_hc",  32'(hc_c), 0);
    check_val("c_wrap_vc",  32'(vc_c), 0);
    check_val("c_wrap_sof", 32'(sof_c), 1);
    check_val("c_wrap_eol", 32'(eol_c), 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check_val("c_fc1", 32'(fc_c), 1);
`endif
    en_c = 1'b0;
    tick();
    check_val("c_hold_sof", 32'(sof_c), 1);
    check_val("c_hold_hc",  32'(hc_c), 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check_val("c_hold_fc", 32'(fc_c), 1);
`endif
    en_c = 1'b1;
    tick();
    check_val("c_after_sof", 32'(sof_c), 0);
    check_val("c_after_hc",  32'(hc_c), 1);
    repeat (34) tick();
    check_val("c_f2_sof", 32'(sof_c), 1);
    repeat (35) tick();
    check_val("c_f3_sof", 32'(sof_c), 1);
    check_val("c_f3_hc",  32'(hc_c), 0);
    check_val("c_f3_vc",  32'(vc_c), 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check_val("c_fc3", 32'(fc_c), 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
